// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy encoding, NOP bubble and IF/ID payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IF_ID_W = PC_W + INSTR_W;

  // addi x0,x0,0: what a bubble decodes to in instruction-carrying stages
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, flush-to-bubble
// and an optional 2-entry skid buffer that makes in_ready_o flop-driven.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_hs, out_hs;

  assign out_valid_o = (state_q != OCC_EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = 2'(state_q);

  // SKID=1 keeps ready off the downstream ready path; SKID=0 passes it through
  if (SKID) begin : g_ready_reg
    assign in_ready_o = (state_q != OCC_SKID);
  end else begin : g_ready_comb
    assign in_ready_o = out_ready_i | ~out_valid_o;
  end

  assign in_hs  = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // a beat accepted this cycle is consumed but not stored
      state_d = OCC_EMPTY;
      if (CLEAR_DATA) begin
        main_d = BUBBLE_VAL;
        skid_d = BUBBLE_VAL;
      end
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_hs) begin
            state_d = OCC_FULL;
            main_d  = in_data_i;
          end
        end
        OCC_FULL: begin
          if (in_hs && out_hs) begin
            main_d = in_data_i;
          end else if (in_hs) begin
            state_d = OCC_SKID;
            skid_d  = in_data_i;
          end else if (out_hs) begin
            state_d = OCC_EMPTY;
            if (CLEAR_DATA) main_d = BUBBLE_VAL;
          end
        end
        OCC_SKID: begin
          if (out_hs) begin
            state_d = OCC_FULL;
            main_d  = skid_q;
            if (CLEAR_DATA) skid_d = BUBBLE_VAL;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: skid instance (CLEAR_DATA=1) and single-entry instance (CLEAR_DATA=0).
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] BUB = {32'h0, NOP_INSTR};

  logic clk = 1'b0;
  logic rst;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1'b1), .BUBBLE_VAL(BUB), .CLEAR_DATA(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .occupancy_o(a_occ)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(1'b0), .BUBBLE_VAL(BUB), .CLEAR_DATA(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .occupancy_o(b_occ)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] occ, input logic rdy);
    chk({tag, ".valid"}, DW'(a_out_valid), DW'(v));
    chk({tag, ".data"},  a_out_data, d);
    chk({tag, ".occ"},   DW'(a_occ), DW'(occ));
    chk({tag, ".ready"}, DW'(a_in_ready), DW'(rdy));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] occ, input logic rdy);
    chk({tag, ".valid"}, DW'(b_out_valid), DW'(v));
    chk({tag, ".data"},  b_out_data, d);
    chk({tag, ".occ"},   DW'(b_occ), DW'(occ));
    chk({tag, ".ready"}, DW'(b_in_ready), DW'(rdy));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] va, vb, vc;
    va = 64'hAAAA_0000_0000_0001;
    vb = 64'hBBBB_0000_0000_0002;
    vc = 64'hCCCC_0000_0000_0003;

    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    cyc(); cyc();
    chk_a("reset_a", 1'b0, BUB, 2'd0, 1'b1);
    chk_b("reset_b", 1'b0, BUB, 2'd0, 1'b1);
    rst = 1'b0;

    // 1: first beat, then 8-beat stream at full rate
    a_in_valid = 1'b1; a_in_data = 64'h0000_0004_0000_0013; a_out_ready = 1'b1;
    cyc();
    chk_a("first", 1'b1, 64'h0000_0004_0000_0013, 2'd1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      a_in_data = DW'(k);
      cyc();
      chk_a($sformatf("stream%0d", k), 1'b1, DW'(k), 2'd1, 1'b1);
    end
    a_in_valid = 1'b0;
    cyc();
    chk_a("drain", 1'b0, BUB, 2'd0, 1'b1);

    // 2: back-pressure fills skid, then drains in order
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = va;
    cyc();
    chk_a("bp_a", 1'b1, va, 2'd1, 1'b1);
    a_in_data = vb;
    cyc();
    chk_a("bp_b", 1'b1, va, 2'd2, 1'b0);
    a_in_valid = 1'b0;
    cyc();
    chk_a("bp_hold", 1'b1, va, 2'd2, 1'b0);
    a_out_ready = 1'b1;
    cyc();
    chk_a("bp_outb", 1'b1, vb, 2'd1, 1'b1);
    cyc();
    chk_a("bp_empty", 1'b0, BUB, 2'd0, 1'b1);

    // 3: flush at occupancy 2 with beat C presented
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = va;
    cyc();
    a_in_data = vb;
    cyc();
    chk_a("pre_flush", 1'b1, va, 2'd2, 1'b0);
    a_in_data = vc; a_flush = 1'b1;
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk_a("flush", 1'b0, BUB, 2'd0, 1'b1);
    a_out_ready = 1'b1;
    cyc();
    chk_a("flush_noc", 1'b0, BUB, 2'd0, 1'b1);
    // input handshake coincident with flush is discarded
    a_in_valid = 1'b1; a_in_data = vc; a_flush = 1'b1;
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk_a("flush_in", 1'b0, BUB, 2'd0, 1'b1);

    // 5: async reset mid-cycle at occupancy 2
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = va;
    cyc();
    a_in_data = vb;
    cyc();
    a_in_valid = 1'b0;
    chk_a("pre_rst", 1'b1, va, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, BUB, 2'd0, 1'b1);
    cyc();
    rst = 1'b0;

    // 6: SKID=0, CLEAR_DATA=0
    b_in_valid = 1'b1; b_in_data = va; b_out_ready = 1'b0;
    cyc();
    b_in_valid = 1'b0;
    #1;
    chk_b("b_full", 1'b1, va, 2'd1, 1'b0);
    b_out_ready = 1'b1;
    #1;
    chk("b_ready_comb", DW'(b_in_ready), DW'(1'b1));
    b_out_ready = 1'b0; b_flush = 1'b1;
    cyc();
    b_flush = 1'b0;
    chk_b("b_flush", 1'b0, va, 2'd0, 1'b1);
    b_in_valid = 1'b1; b_in_data = vb; b_out_ready = 1'b1;
    cyc();
    chk_b("b_s1", 1'b1, vb, 2'd1, 1'b1);
    b_in_data = vc;
    cyc();
    chk_b("b_s2", 1'b1, vc, 2'd1, 1'b1);
    b_in_valid = 1'b0;
    cyc();
    chk_b("b_empty", 1'b0, vc, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
